// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - N-channel arbitrated mux with one registered output slot
module rr_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SELW     = 3,
    parameter int RR       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_ch,
    input  logic                      out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  g;
    logic [SELW-1:0]  g_hi;
    logic [SELW-1:0]  g_lo;
    logic             hit_hi;
    logic             hit_lo;
    logic             gnt;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    assign load = !out_valid || out_ready;
    assign xfer = gnt && load;

    // Lowest requester at/above ptr (hi) and lowest below ptr (lo); every lo index is below every hi index.
    always_comb begin
        g      = '0;
        gnt    = 1'b0;
        g_hi   = '0;
        g_lo   = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (SELW'(i) >= ptr) begin
                    hit_hi = 1'b1;
                    g_hi   = SELW'(i);
                end else begin
                    hit_lo = 1'b1;
                    g_lo   = SELW'(i);
                end
            end
        end
        if (force_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (force_sel == SELW'(i)) begin
                    g   = force_sel;
                    gnt = in_valid[i];
                end
            end
        end else begin
            gnt = hit_hi || hit_lo;
            if (RR != 0) begin
                g = hit_hi ? g_hi : g_lo;
            end else begin
                g = hit_lo ? g_lo : g_hi;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (g == SELW'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= g;
                if (RR != 0 && !force_en) begin
                    ptr <= (g == SELW'(CHANNELS - 1)) ? '0 : g + SELW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
